// File: rtl/uart_tx.sv
// UART serializer: start bit, DBIT data bits LSB first, stop period.
// Paced by the shared 16x oversampling tick.
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_tick,
  input  logic            i_tx_start,
  input  logic [DBIT-1:0] i_data,
  output logic            o_tx,
  output logic            o_busy,
  output logic            o_tx_done
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [4:0] S_LAST    = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

  state_t          state;
  logic [4:0]      s;
  logic [2:0]      n;
  logic [DBIT-1:0] b;
  logic            tx;
  logic            tx_done;

  // tx is loaded with the level of the state being entered,
  // so the line changes on the same edge as the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      s       <= '0;
      n       <= '0;
      b       <= '0;
      tx      <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (i_tx_start) begin
            b     <= i_data;
            s     <= '0;
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (i_tick) begin
            if (s == S_LAST) begin
              s     <= '0;
              n     <= '0;
              state <= DATA;
              tx    <= b[0];
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        DATA: begin
          if (i_tick) begin
            if (s == S_LAST) begin
              s <= '0;
              b <= b >> 1;
              if (n == N_LAST) begin
                state <= STOP;
                tx    <= 1'b1;
              end else begin
                n  <= n + 3'd1;
                tx <= b[1];
              end
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        STOP: begin
          if (i_tick) begin
            if (s == STOP_LAST) begin
              state   <= IDLE;
              tx_done <= 1'b1;
              tx      <= 1'b1;
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  assign o_tx      = tx;
  assign o_busy    = (state != IDLE);
  assign o_tx_done = tx_done;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: 8N1/16-tick and 7-bit/32-tick instances,
// line decoded at mid-bit against expected frame images.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       start0, start1;
  logic [7:0] data0;
  logic [6:0] data1;
  logic       tx0, busy0, done0;
  logic       tx1, busy1, done1;
  logic       sel;
  logic       tx_m, busy_m, done_m;

  int total = 0;
  int bad   = 0;
  int nd0   = 0;
  int nd1   = 0;
  int cyc   = 0;
  int tcnt  = 0;

  uart_tx #(.DBIT(8), .SB_TICK(16)) u_tx8 (
    .i_clk(clk), .i_rst(rst), .i_tick(tick),
    .i_tx_start(start0), .i_data(data0),
    .o_tx(tx0), .o_busy(busy0), .o_tx_done(done0)
  );

  uart_tx #(.DBIT(7), .SB_TICK(32)) u_tx7 (
    .i_clk(clk), .i_rst(rst), .i_tick(tick),
    .i_tx_start(start1), .i_data(data1),
    .o_tx(tx1), .o_busy(busy1), .o_tx_done(done1)
  );

  assign tx_m   = sel ? tx1 : tx0;
  assign busy_m = sel ? busy1 : busy0;
  assign done_m = sel ? done1 : done0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tcnt++;
      tick = (tcnt % 4 == 0);
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (done0) nd0++;
    if (done1) nd1++;
  end

  typedef struct {
    logic [7:0] d;
    logic [9:0] line;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic wait_ticks(input int k);
    int c;
    c = 0;
    while (c < k) begin
      @(posedge clk);
      if (tick) c++;
    end
    #2;
  endtask

  function automatic logic [9:0] frame_bits(input logic [7:0] d,
                                            input int dbit);
    logic [9:0] f;
    f = '0;
    for (int i = 0; i < dbit; i++) f[i+1] = d[i];
    f[dbit+1] = 1'b1;
    return f;
  endfunction

  task automatic send(input logic [7:0] d, input bit align);
    if (align)
      while (!tick) begin
        @(posedge clk);
        #2;
      end
    if (sel) begin
      start1 = 1'b1;
      data1  = d[6:0];
    end else begin
      start0 = 1'b1;
      data0  = d;
    end
    @(posedge clk);
    #2;
    start0 = 1'b0;
    start1 = 1'b0;
    data0  = 8'($urandom);
    data1  = 7'($urandom);
  endtask

  // Called just after the accept edge; returns in the done cycle.
  task automatic check_frame(input logic [9:0] exp, input int dbit,
                             input int sbt, input string nm);
    logic [9:0] got;
    int nd;
    got = '0;
    nd  = sel ? nd1 : nd0;
    chk({nm, "_start"}, {30'd0, tx_m, busy_m}, 32'b01);
    wait_ticks(8);
    got[0] = tx_m;
    for (int j = 1; j <= dbit + 1; j++) begin
      wait_ticks(16);
      got[j] = tx_m;
    end
    chk({nm, "_line"}, {22'd0, got}, {22'd0, exp});
    wait_ticks(sbt - 9);
    chk({nm, "_predone"}, {29'd0, tx_m, busy_m, done_m}, 32'b110);
    wait_ticks(1);
    chk({nm, "_done"}, {29'd0, tx_m, busy_m, done_m}, 32'b101);
    chk({nm, "_ndone"}, 32'((sel ? nd1 : nd0) - nd), 32'd1);
  endtask

  initial begin
    int c0, n0;
    logic [7:0] d;
    sel    = 1'b0;
    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    data0  = '0;
    data1  = '0;
    tbl[0] = '{8'h00, 10'h200};
    tbl[1] = '{8'hFF, 10'h3FE};
    tbl[2] = '{8'h55, 10'h2AA};
    tbl[3] = '{8'h80, 10'h300};
    tbl[4] = '{8'h3C, 10'h278};

    repeat (3) @(posedge clk);
    #2;
    chk("reset8", {29'd0, tx0, busy0, done0}, 32'b100);
    chk("reset7", {29'd0, tx1, busy1, done1}, 32'b100);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // single 0xA5 frame, tick-aligned accept
    send(8'hA5, 1'b1);
    c0 = cyc;
    check_frame(10'h34A, 8, 16, "a5");
    chk("a5_len", 32'(cyc - c0), 32'd640);
    @(posedge clk);
    #2;
    chk("a5_done_1cyc", {31'd0, done0}, 32'd0);

    // loopback table
    for (int i = 0; i < 4; i++) begin
      send(tbl[i].d, 1'b1);
      check_frame(tbl[i].line, 8, 16, $sformatf("tbl%0d", i));
      repeat (5) @(posedge clk);
      #2;
    end

    // request while busy is ignored
    n0 = nd0;
    send(tbl[4].d, 1'b1);
    fork
      check_frame(tbl[4].line, 8, 16, "busy");
      begin
        wait_ticks(60);
        start0 = 1'b1;
        data0  = 8'hC3;
        @(posedge clk);
        #2;
        start0 = 1'b0;
      end
    join
    repeat (200) @(posedge clk);
    #2;
    chk("busy_idle", {30'd0, tx0, busy0}, 32'b10);
    chk("busy_once", 32'(nd0 - n0), 32'd1);

    // back-to-back: second strobe in the done cycle
    send(8'h34, 1'b1);
    check_frame(10'h268, 8, 16, "b2b_a");
    start0 = 1'b1;
    data0  = 8'h12;
    @(posedge clk);
    #2;
    start0 = 1'b0;
    data0  = 8'hFF;
    check_frame(10'h224, 8, 16, "b2b_b");
    repeat (5) @(posedge clk);
    #2;

    // reset mid-frame, then reset together with a request
    n0 = nd0;
    send(8'h0F, 1'b1);
    wait_ticks(72);
    chk("rst_bit3", {31'd0, tx0}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk("rst_mid", {29'd0, tx0, busy0, done0}, 32'b100);
    start0 = 1'b1;
    data0  = 8'hAA;
    @(posedge clk);
    #2;
    rst    = 1'b0;
    start0 = 1'b0;
    chk("rst_start", {30'd0, tx0, busy0}, 32'b10);
    repeat (100) @(posedge clk);
    #2;
    chk("rst_nodone", 32'(nd0 - n0), 32'd0);
    chk("rst_idle", {30'd0, tx0, busy0}, 32'b10);
    send(8'hF0, 1'b0);
    check_frame(10'h3E0, 8, 16, "after_rst");

    // 7 data bits, 2 stop bits
    sel = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    send(8'h41, 1'b1);
    c0 = cyc;
    check_frame(10'h182, 7, 32, "d7");
    chk("d7_len", 32'(cyc - c0), 32'd640);

    // randomized frames on either instance, random phase and gaps
    for (int k = 0; k < 16; k++) begin
      sel = 1'($urandom);
      d   = 8'($urandom);
      repeat ($urandom_range(0, 9)) @(posedge clk);
      #2;
      send(d, 1'($urandom));
      if (sel)
        check_frame(frame_bits(d, 7), 7, 32, $sformatf("rnd%0d", k));
      else
        check_frame(frame_bits(d, 8), 8, 16, $sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
